// File: rtl/ppg_pkg.sv
// Shared PPG pipeline definitions: sample width, buffer depth, address width
// and the capture FSM state encoding, reused by the writer, mean and SNR blocks.
// No logic; constants and types only.
package ppg_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int MEMORY_DEPTH = 5968;
    localparam int ADDR_WIDTH   = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        LOADED  = 2'd2
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// Sample storage: simple dual-port RAM, synchronous write, registered read.
// Latency: read data valid one cycle after rd_addr; a same-cycle write is not visible (old data).
// Backpressure: none; writes are accepted whenever wr_en is high and the address is in range.
// Ports: clk/reset, write port (wr_en, wr_addr, wr_data), read port (rd_addr -> rd_data).
module sample_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 5968,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Array deliberately has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < DEPTH_A)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; out-of-range reads return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_addr < DEPTH_A) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/sample_buffer_writer.sv
// Captures one frame of PPG samples into a buffer and holds it until the consumer clears it.
// Latency: sample written on the accepting edge; loaded/status valid the next cycle; reads 1 cycle.
// Backpressure: s_ready is high only while capturing (decoded from state, no path from s_valid).
// Ports: clk/reset, start/clear control, s_valid/s_ready/s_data/s_last sample stream,
//        read_address -> data_out read port, loaded/sample_count/short_frame status.
module sample_buffer_writer #(
    parameter int DATA_WIDTH   = ppg_pkg::DATA_WIDTH,
    parameter int MEMORY_DEPTH = ppg_pkg::MEMORY_DEPTH,
    parameter int ADDR_WIDTH   = ppg_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  loaded,
    output logic [ADDR_WIDTH-1:0] sample_count,
    output logic                  short_frame
);

    import ppg_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEMORY_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   write_ptr;
    logic                    xfer;
    logic                    at_last_slot;

    assign s_ready      = (state_q == CAPTURE);
    assign loaded       = (state_q == LOADED);
    assign xfer         = s_valid && s_ready;
    assign at_last_slot = (write_ptr == LAST_A);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start is only honoured in IDLE and clear only in LOADED, so a
    // simultaneous start+clear in LOADED naturally resolves to clear.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (xfer && (at_last_slot || s_last)) begin
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // write_ptr stops at MEMORY_DEPTH because the filling transfer leaves CAPTURE.
    // sample_count is kept after clear so the consumer can still size the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_ptr    <= '0;
            sample_count <= '0;
            short_frame  <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            write_ptr    <= '0;
            sample_count <= '0;
            short_frame  <= 1'b0;
        end else if (xfer) begin
            write_ptr <= write_ptr + ONE_A;
            if (sample_count != DEPTH_A) begin
                sample_count <= sample_count + ONE_A;
            end
            // s_last on the final slot is still a full frame.
            if (s_last && !at_last_slot) begin
                short_frame <= 1'b1;
            end
        end
    end

    sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sample_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (xfer),
        .wr_addr (write_ptr),
        .wr_data (s_data),
        .rd_addr (read_address),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_sample_buffer_writer.sv
// Bench for sample_buffer_writer: random-data stimulus against a frame-level reference model.
// Inputs driven and outputs sampled on the falling clock edge.
// Model keeps the expected RAM image, the current frame as a queue, and the buffer status.
module tb_sample_buffer_writer;

    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int DEPTH = 5968;

    localparam int M_IDLE   = 0;
    localparam int M_CAP    = 1;
    localparam int M_LOADED = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          clear;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [AW-1:0] read_address;
    logic [DW-1:0] data_out;
    logic          loaded;
    logic [AW-1:0] sample_count;
    logic          short_frame;

    int n_checks;
    int n_errors;

    // Reference model
    int            m_st;
    logic [DW-1:0] m_frame [$];
    logic          m_short;
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];

    sample_buffer_writer #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear        (clear),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .read_address (read_address),
        .data_out     (data_out),
        .loaded       (loaded),
        .sample_count (sample_count),
        .short_frame  (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, advance the model by the
    // rules of the block, then check the outputs at the next falling edge.
    task automatic cycle(input logic st, input logic cl, input logic v, input logic lst,
                         input logic [DW-1:0] d, input logic [AW-1:0] ra);
        logic          rd_known;
        logic [DW-1:0] rd_exp;
        logic [AW-1:0] wa;
        start        = st;
        clear        = cl;
        s_valid      = v;
        s_last       = lst;
        s_data       = d;
        read_address = ra;
        #1;
        chk("s_ready", 32'(s_ready), 32'(m_st == M_CAP));

        // Read returns the contents before this cycle's write.
        rd_known = 1'b1;
        rd_exp   = '0;
        if (int'(ra) < DEPTH) begin
            rd_known = m_known[ra];
            rd_exp   = m_mem[ra];
        end

        if (m_st == M_IDLE && st) begin
            m_st = M_CAP;
            m_frame.delete();
            m_short = 1'b0;
        end else if (m_st == M_CAP && v) begin
            wa          = AW'(m_frame.size());
            m_mem[wa]   = d;
            m_known[wa] = 1'b1;
            m_frame.push_back(d);
            if (m_frame.size() == DEPTH) begin
                m_st = M_LOADED;
            end else if (lst) begin
                m_st    = M_LOADED;
                m_short = 1'b1;
            end
        end else if (m_st == M_LOADED && cl) begin
            m_st = M_IDLE;
        end

        @(negedge clk);
        chk("loaded", 32'(loaded), 32'(m_st == M_LOADED));
        chk("sample_count", 32'(sample_count), 32'(m_frame.size()));
        chk("short_frame", 32'(short_frame), 32'(m_short));
        if (rd_known) chk("data_out", 32'(data_out), 32'(rd_exp));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start   = 1'b0;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_short", 32'(short_frame), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        m_st = M_IDLE;
        m_frame.delete();
        m_short = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, DEPTH + 100));
    endfunction

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        s_data       = '0;
        read_address = '0;
        m_st         = M_IDLE;
        m_short      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end

        do_reset();

        // Idle: clear is ignored, s_valid is held off.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, rnd(), '0);

        // Full frame, data = address, s_last on the final slot still counts as full.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1 && (i == DEPTH - 1), DW'(i), rnd_addr());
        end
        chk("full_count", 32'(sample_count), 32'(DEPTH));
        chk("full_short", 32'(short_frame), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(0));
        chk("full_rd0", 32'(data_out), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(100));
        chk("full_rd100", 32'(data_out), 32'd100);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(5967));
        chk("full_rd5967", 32'(data_out), 32'd5967);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(6000));
        chk("rd_out_of_range", 32'(data_out), 32'd0);
        // Start in LOADED is ignored, clear releases.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, rnd(), rnd_addr());
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, rnd_addr());

        // Short frame of 10, with stray s_last on idle cycles (no s_valid).
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd_addr());
            cycle(1'b0, 1'b0, 1'b1, 1'b1 && (i == 9), rnd(), rnd_addr());
        end
        chk("short_count", 32'(sample_count), 32'd10);
        chk("short_flag", 32'(short_frame), 32'd1);
        chk("short_s_ready", 32'(s_ready), 32'd0);
        // Start and clear together in LOADED: clear wins, block returns to idle.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, rnd_addr());
        chk("startclear_loaded", 32'(loaded), 32'd0);
        chk("startclear_ready", 32'(s_ready), 32'd0);

        // Back-pressure: s_valid toggling, stray start/clear during capture,
        // read at the write address every cycle (must see old data).
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1 && ($urandom_range(0, 3) == 0), 1'b1 && ($urandom_range(0, 3) == 0),
                  1'(i % 2), 1'b1 && ((i % 2) == 1) && (m_frame.size() == 39),
                  rnd(), AW'(m_frame.size()));
        end
        chk("bp_count", 32'(sample_count), 32'd40);
        // Upstream keeps offering while LOADED: nothing may be written.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'(i % 3 == 0), rnd(), AW'(40 + i));
        end
        for (int i = 0; i < 41; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(i));
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a capture abandons the frame.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, rnd(), rnd_addr());
        end
        chk("mid_count", 32'(sample_count), 32'd50);
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, rnd(), '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, DW'(16'hA000 + i), AW'(0));
        end
        chk("restart_count", 32'(sample_count), 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, AW'(0));
        chk("restart_addr0", 32'(data_out), 32'h0000A000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sample_buffer_writer.md
SAMPLE_BUFFER_WRITER -- requirements
Module: sample_buffer_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL be the sample width in bits.
REQ-002 Parameter MEMORY_DEPTH, default 5968, SHALL be the buffer depth in samples.
REQ-003 Parameter ADDR_WIDTH, default 13, SHALL be the address and count width, with 2^ADDR_WIDTH > MEMORY_DEPTH.
REQ-004 clk  input  1  SHALL be the clock; all logic is rising-edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 start  input  1  SHALL be the pulse that arms a capture.
REQ-007 clear  input  1  SHALL be the pulse that releases the loaded buffer.
REQ-008 s_valid  input  1  SHALL flag that the upstream sample is valid.
REQ-009 s_ready  output  1  SHALL flag that the block accepts a sample.
REQ-010 s_data  input  DATA_WIDTH  SHALL be the PPG sample.
REQ-011 s_last  input  1  SHALL mark the final sample of a frame.
REQ-012 read_address  input  ADDR_WIDTH  SHALL be the consumer read address.
REQ-013 data_out  output  DATA_WIDTH  SHALL be the registered read data.
REQ-014 loaded  output  1  SHALL be high while the buffer holds a complete frame.
REQ-015 sample_count  output  ADDR_WIDTH  SHALL be the number of samples written in the current or last frame.
REQ-016 short_frame  output  1  SHALL be high when the frame ended on s_last before MEMORY_DEPTH samples.

Function
REQ-017 The FSM SHALL have three states: IDLE, CAPTURE and LOADED.
REQ-018 IDLE SHALL go to CAPTURE on start, zeroing write_ptr, sample_count and short_frame on the same edge.
REQ-019 s_ready SHALL equal (state==CAPTURE) and SHALL be driven from registered state only, with no combinational path from s_valid.
REQ-020 A transfer SHALL occur on a cycle with s_valid && s_ready; it writes s_data to RAM[write_ptr] and increments write_ptr and sample_count.
REQ-021 A transfer at write_ptr==MEMORY_DEPTH-1 SHALL move CAPTURE to LOADED; loaded=1 and sample_count=MEMORY_DEPTH on the next cycle.
REQ-022 A transfer with s_last=1 and write_ptr<MEMORY_DEPTH-1 SHALL move CAPTURE to LOADED with short_frame=1.
REQ-023 s_last on the transfer at write_ptr==MEMORY_DEPTH-1 SHALL be a normal full frame with short_frame=0.
REQ-024 s_last without s_valid SHALL be ignored.
REQ-025 In LOADED, s_ready SHALL be 0 and upstream samples SHALL be held off, never dropped.
REQ-026 clear in LOADED SHALL go to IDLE with loaded=0; RAM contents and sample_count SHALL be retained.
REQ-027 start in CAPTURE or LOADED SHALL be ignored.
REQ-028 clear in IDLE or CAPTURE SHALL be ignored.
REQ-029 If start and clear arrive together in LOADED, clear SHALL take effect and start SHALL be ignored.
REQ-030 Reads SHALL have 1-cycle latency: data_out is valid on the cycle after read_address is presented, in any state.
REQ-031 read_address >= MEMORY_DEPTH SHALL return data_out=0.
REQ-032 A read and a write to the same address on the same cycle SHALL return the old data.
REQ-033 sample_count SHALL saturate at MEMORY_DEPTH and write_ptr SHALL never wrap.

Reset
REQ-034 Reset SHALL force state=IDLE, s_ready=0, loaded=0, short_frame=0, sample_count=0, write_ptr=0 and data_out=0.
REQ-035 Reset SHALL NOT initialise RAM contents.
REQ-036 Reset asserted mid-CAPTURE SHALL abandon the frame; after reset release the block returns to IDLE and requires a new start.

Structure
REQ-037 DATA_WIDTH, MEMORY_DEPTH, ADDR_WIDTH and the FSM state enum SHALL live in a shared package, ppg_pkg, reused by the mean and SNR blocks.
REQ-038 The storage SHALL be one sub-module, sample_ram: simple dual-port, one synchronous write port and one registered read port, with no reset on the array.
REQ-039 The FSM, counters and handshake logic SHALL live in sample_buffer_writer.

Verification
REQ-040 Full frame: start, then 5968 back-to-back transfers of data=address -> loaded=1 one cycle after the last transfer, sample_count=5968, short_frame=0; read addresses 0, 100 and 5967 -> data_out=0, 100, 5967 one cycle later.
REQ-041 Short frame: start, then 10 transfers with s_last on the 10th -> loaded=1, sample_count=10, short_frame=1, s_ready=0.
REQ-042 Back-pressure: s_valid toggled every cycle, plus s_valid held high in LOADED for 20 cycles -> no sample lost or duplicated, no write while in LOADED, RAM matches the input sequence.
REQ-043 Mid-capture reset: reset after 50 transfers -> all outputs return to reset values; the next start begins at address 0 with sample_count counting from 0.
REQ-044 Control corners: start and clear together in LOADED -> state=IDLE; start during CAPTURE -> no change to write_ptr.
REQ-045 Read corners: read_address=6000 -> data_out=0; read and write to the same address on the same cycle -> data_out shows the old value.
